au_cmp_serial: RTL
==================

// Module: au_cmp_serial
// PURPOSE
//  Digit-serial magnitude/equality comparator. Compares WIDTH-bit a and b DIGIT bits per cycle, MSB digit first.
//  Terminates early on the first differing digit and returns one-hot eq/lt/gt.
//  Supports unsigned or two's-complement operands, selected per transaction.
//  Valid/ready on both sides. Used where a full-width single-cycle comparator is too wide or too slow for timing.
// PARAMETERS
//  WIDTH  32  operand word length (>= 1)
//  DIGIT  8   bits compared per cycle (1..WIDTH); NDIG = ceil(WIDTH/DIGIT) digits, EXT = NDIG*DIGIT
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      operands/mode valid
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  tc         in   1      1 = two's-complement compare, 0 = unsigned
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  eq         out  1      a == b
//  lt         out  1      a <  b (per tc)
//  gt         out  1      a >  b (per tc)
// BEHAVIOUR
//  Reset: one clock, synchronous, active-high. While rst=1 at an edge, state -> IDLE.
//   Reset values: out_valid=0, eq=lt=gt=0, digit counter=0. in_ready=0 while rst is high.
//  FSM states: IDLE, RUN, DONE (2-bit register). in_ready = (state==IDLE) & ~rst; out_valid = (state==DONE).
//  IDLE:
//   - in_valid & in_ready -> capture operands, cnt=NDIG-1, go RUN.
//   - Operands extended to EXT bits: zero-extended if tc=0, sign-extended if tc=1.
//   - If tc=1, bit EXT-1 of both is then inverted, so all later compares are unsigned.
//  RUN (one digit per cycle, digit index cnt):
//   - digits differ -> set lt/gt from that digit's unsigned compare, eq=0, go DONE.
//   - digits equal and cnt==0 -> eq=1, lt=gt=0, go DONE.
//   - otherwise cnt <= cnt-1, stay RUN.
//  DONE:
//   - eq/lt/gt are one-hot and held stable while out_valid & ~out_ready.
//   - out_ready -> go IDLE and clear eq/lt/gt to 0.
//  Latency:
//   - k RUN cycles, where k = (position of the first differing digit from the MSB) + 1, or NDIG if a==b.
//   - out_valid rises k cycles after the accept edge.
//   - Minimum per-transaction occupancy is k+2 cycles (accept, RUN x k, DONE handshake).
//  No new accept while RUN/DONE; in_valid is ignored there. Operands are captured, so a/b may change after accept.
//  Boundaries:
//   - WIDTH not a multiple of DIGIT: top digit is padded per extension rule.
//   - DIGIT=WIDTH: always exactly 1 RUN cycle.
//   - Reset mid-RUN or mid-DONE aborts the transaction; the result is discarded; in_ready=1 the cycle after rst falls.
//  cnt width = max(1,$clog2(NDIG)); cnt never wraps below 0.
// STRUCTURE
//  - State encoding and NDIG/EXT derivation are localparams; they go in shared include au_cmp_defs.vh for reuse by future comparator variants.
//  - One combinational sub-module au_cmp_digit #(DIGIT): inputs x,y; outputs deq, dgt.
//  - Digit select is a mux on cnt over the captured EXT-bit registers; no shifting of operand registers.
// TESTING (WIDTH=32, DIGIT=8 unless noted)
//  - a=b=0x12345678, tc=0 -> eq=1, lt=gt=0; out_valid exactly 4 cycles after accept.
//  - a=0x80000000, b=0x00000001, tc=0 -> gt=1 after 1 RUN cycle; same operands with tc=1 -> lt=1 after 1 cycle.
//  - a=0x12345679, b=0x12345678, tc=0 -> gt=1 after 4 cycles; swap operands -> lt=1.
//  - Backpressure: hold out_ready=0 for 5 cycles -> out_valid=1 and results constant; in_ready=0; in_valid pulses ignored.
//  - Assert rst on 2nd RUN cycle -> next edge out_valid=0, eq=lt=gt=0; in_ready=1 after rst drops; next transaction correct.
//  - WIDTH=13, DIGIT=4, tc=1, a=0x1FFF (-1), b=0x0000 -> lt=1 after 1 cycle; tc=0 -> gt=1 after 1 cycle.

Source files
------------

// File: rtl/au_cmp_serial_pkg.sv
// ---------------------------------------------------------------------------
// au_cmp_serial_pkg
//   Shared definitions for the digit-serial comparator family.
//   Holds the FSM state encoding and the helpers that work out the digit
//   count and counter width from the operand width and the digit width.
//   Future comparator variants can import this package to use the same
//   derivations.
// ---------------------------------------------------------------------------
package au_cmp_serial_pkg;

   // Two-bit state register: idle, walking the digits, result held
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Number of digits needed to cover the operand, rounding up
   function automatic int calc_ndig(input int width, input int digit);
      return (width + digit - 1) / digit;
   endfunction

   // The digit counter must be at least one bit wide, even when there is
   // only a single digit
   function automatic int calc_cnt_w(input int ndig);
      return (ndig > 1) ? $clog2(ndig) : 1;
   endfunction

endpackage

// File: rtl/au_cmp_serial_digit.sv
// ---------------------------------------------------------------------------
// au_cmp_digit
//   Purely combinational compare of one unsigned digit.
//   Ports:
//     x, y  in  DIGIT  digits to compare
//     deq   out 1      x == y
//     dgt   out 1      x >  y (unsigned)
// ---------------------------------------------------------------------------
module au_cmp_digit #(
   parameter int DIGIT = 8
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   output logic             deq,
   output logic             dgt
);

   assign deq = (x == y);
   assign dgt = (x > y);

endmodule

// File: rtl/au_cmp_serial.sv
// ---------------------------------------------------------------------------
// au_cmp_serial
//   Digit-serial magnitude/equality comparator. Compares a and b DIGIT bits
//   per cycle, most significant digit first, and stops at the first digit
//   that differs. Operands are treated as unsigned (tc=0) or two's
//   complement (tc=1), chosen per transaction.
//   Ports:
//     clk, rst             clock and synchronous active-high reset
//     in_valid / in_ready  operand handshake (a, b, tc)
//     out_valid / out_ready result handshake (eq, lt, gt, one-hot)
// ---------------------------------------------------------------------------
module au_cmp_serial
   import au_cmp_serial_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIGIT = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             tc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             eq,
   output logic             lt,
   output logic             gt
);

   localparam int NDIG = calc_ndig(WIDTH, DIGIT);
   localparam int EXT  = NDIG * DIGIT;
   localparam int CW   = calc_cnt_w(NDIG);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q,   cnt_d;
   logic [EXT-1:0]  a_q,     a_d;
   logic [EXT-1:0]  b_q,     b_d;
   logic            eq_q,    eq_d;
   logic            lt_q,    lt_d;
   logic            gt_q,    gt_d;

   logic [EXT-1:0]  a_ext, b_ext;
   logic [DIGIT-1:0] a_dig, b_dig;
   logic            dig_eq, dig_gt;

   // Widen the operands to a whole number of digits. In two's-complement
   // mode the sign is replicated, then the top bit is flipped so that the
   // signed order becomes plain unsigned order for the digit compares.
   always_comb begin
      a_ext = EXT'(a);
      b_ext = EXT'(b);
      for (int i = WIDTH; i < EXT; i++) begin
         a_ext[i] = tc & a[WIDTH-1];
         b_ext[i] = tc & b[WIDTH-1];
      end
      if (tc) begin
         a_ext[EXT-1] = ~a_ext[EXT-1];
         b_ext[EXT-1] = ~b_ext[EXT-1];
      end
   end

   // Pick the current digit straight out of the captured registers; the
   // operand registers never shift, only the counter moves
   assign a_dig = a_q[int'(cnt_q) * DIGIT +: DIGIT];
   assign b_dig = b_q[int'(cnt_q) * DIGIT +: DIGIT];

   au_cmp_digit #(.DIGIT(DIGIT)) u_digit (
      .x   (a_dig),
      .y   (b_dig),
      .deq (dig_eq),
      .dgt (dig_gt)
   );

   // Next-state logic: accept in idle, walk digits in run, hold the result
   // until the consumer takes it
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      eq_d    = eq_q;
      lt_d    = lt_q;
      gt_d    = gt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = a_ext;
               b_d     = b_ext;
               cnt_d   = CW'(NDIG - 1);
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!dig_eq) begin
               eq_d    = 1'b0;
               gt_d    = dig_gt;
               lt_d    = ~dig_gt;
               state_d = ST_DONE;
            end else if (cnt_q == '0) begin
               eq_d    = 1'b1;
               lt_d    = 1'b0;
               gt_d    = 1'b0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               eq_d    = 1'b0;
               lt_d    = 1'b0;
               gt_d    = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and result registers; reset aborts whatever is in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         eq_q    <= 1'b0;
         lt_q    <= 1'b0;
         gt_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         eq_q    <= eq_d;
         lt_q    <= lt_d;
         gt_q    <= gt_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE) & ~rst;
   assign out_valid = (state_q == ST_DONE);
   assign eq        = eq_q;
   assign lt        = lt_q;
   assign gt        = gt_q;

endmodule
